// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_op_e    - {is_store, funct3} encodings for LB/LH/LW/LBU/LHU/SB/SH/SW
//   lsu_state_e - LSU sequencing states
//   SIZE_*      - access size codes (funct3[1:0] of a defined op)
//   op_defined  - 1 when the 4-bit op is one of the eight legal encodings
//   op_size     - access size; undefined encodings are treated as word
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'b0000,
        OP_LH  = 4'b0001,
        OP_LW  = 4'b0010,
        OP_LBU = 4'b0100,
        OP_LHU = 4'b0101,
        OP_SB  = 4'b1000,
        OP_SH  = 4'b1001,
        OP_SW  = 4'b1010
    } lsu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } lsu_state_e;

    localparam logic [1:0]  SIZE_B = 2'd0;
    localparam logic [1:0]  SIZE_H = 2'd1;
    localparam logic [1:0]  SIZE_W = 2'd2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    function automatic logic op_defined(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: op_defined = 1'b1;
            default:             op_defined = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        op_size = op_defined(op) ? op[1:0] : SIZE_W;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   op         in  4  : {is_store, funct3}
//   lo         in  2  : byte address bits [1:0]
//   word       in 32  : memory word
//   wdata      in 32  : right-aligned store data
//   load_data  out 32 : selected lane, sign/zero extended (whole word for LW)
//   store_word out 32 : word with the byte/half lane replaced (wdata for SW)
//   misalign   out 1  : misaligned or undefined op
// Macro LSU_MISALIGN_TRAP_EN enables the misalign flag; without it the flag is
// 0 and halfword/word lanes are aligned down (addr[0] resp. addr[1:0] ignored).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misalign
);

    logic [1:0]        size;
    logic [4:0]        boff;
    logic [BYTE_W-1:0] b;
    logic [HALF_W-1:0] h;

    always_comb begin
        size       = op_size(op);
        boff       = {lo, 3'b000};
        b          = word[boff +: BYTE_W];
        h          = lo[1] ? word[31:16] : word[15:0];
        load_data  = word;
        store_word = word;
        misalign   = 1'b0;

        case (size)
            SIZE_B: begin
                // funct3[2] selects the unsigned variant
                load_data = op[2] ? {24'h0, b} : {{24{b[7]}}, b};
                store_word[boff +: BYTE_W] = wdata[7:0];
            end
            SIZE_H: begin
                load_data = op[2] ? {16'h0, h} : {{16{h[15]}}, h};
                if (lo[1]) store_word[31:16] = wdata[15:0];
                else       store_word[15:0]  = wdata[15:0];
            end
            default: begin
                load_data  = word;
                store_word = wdata;
            end
        endcase

`ifdef LSU_MISALIGN_TRAP_EN
        misalign = !op_defined(op)
                 || (size == SIZE_H && lo[0])
                 || (size == SIZE_W && lo != 2'b00);
`endif
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit driving a single-port RAM (addr/val/rw, read data one
// cycle after a read cycle). One request at a time, one response per request.
//   clk, rst_n               : clock, async active-low reset
//   req_valid/req_ready      : request handshake (ready = idle)
//   req_op/addr/wdata        : {is_store,funct3}, byte address, store data
//   rsp_valid/rsp_data/err   : one-cycle response, held data/err
//   mem_addr/wdata/rw/rdata  : RAM port (rw=1 read, rw=0 write)
// Macro LSU_MISALIGN_TRAP_EN: misaligned/undefined ops return rsp_err=1 with no
// memory access; otherwise rsp_err stays 0 and accesses are aligned down.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state, next_state;
    logic [3:0]  op_q;
    logic [1:0]  lo_q;
    logic [31:0] wdata_q;
    logic [31:0] addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    logic        idle;
    logic [3:0]  a_op;
    logic [1:0]  a_lo;
    logic [31:0] a_wdata;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        misalign;

    assign idle = (state == S_IDLE);

    // In IDLE the aligner sees the incoming request (for the misalign decision
    // and the SW word); afterwards it sees the latched request. Its outputs
    // only ever reach the ports through registers.
    assign a_op    = idle ? req_op         : op_q;
    assign a_lo    = idle ? req_addr[1:0]  : lo_q;
    assign a_wdata = idle ? req_wdata      : wdata_q;

    lsu_align u_align (
        .op         (a_op),
        .lo         (a_lo),
        .word       (mem_rdata),
        .wdata      (a_wdata),
        .load_data  (load_data),
        .store_word (store_word),
        .misalign   (misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (misalign)
                        next_state = S_RESP;
                    else if (req_op[3] && op_size(req_op) == SIZE_W)
                        next_state = S_WR;
                    else
                        next_state = S_RD;
                end
            end
            S_RD:    next_state = S_CAP;
            S_CAP:   next_state = op_q[3] ? S_WR : S_RESP;
            S_WR:    next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            lo_q        <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            mem_wdata_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        lo_q    <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        addr_q  <= {req_addr[31:2], 2'b00};
                        if (misalign) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                        end else if (req_op[3] && op_size(req_op) == SIZE_W) begin
                            mem_wdata_q <= store_word;
                        end
                    end
                end
                S_CAP: begin
                    // mem_rdata is the word read in RD; merge or extract it now
                    if (op_q[3]) begin
                        mem_wdata_q <= store_word;
                    end else begin
                        rsp_data_q <= load_data;
                        rsp_err_q  <= 1'b0;
                    end
                end
                S_WR: begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Write strobe decoded from the state register only, so reset drops it
    // asynchronously.
    assign mem_rw    = (state != S_WR);
    assign rsp_valid = (state == S_RESP);
    assign req_ready = idle;
    assign mem_addr  = addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_data  = rsp_data_q;
    // Without LSU_MISALIGN_TRAP_EN the aligner never flags, so this stays 0.
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rw    (mem_rw),
        .mem_rdata (mem_rdata)
    );

    // RAM the DUT talks to: writes whenever rw=0, registered read data.
    logic [31:0] ram [0:15];
    always @(posedge clk) begin
        if (!mem_rw) ram[mem_addr[5:2]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[5:2]];
    end

    // Reference memory contents as seen by the transaction-level model.
    logic [31:0] model_mem [0:15];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Current transaction expectations.
    bit          active = 0;
    int          acc_edge = 0;
    int          t_lat = 0;
    int          t_wcyc = 0;
    logic [31:0] t_data = '0;
    logic        t_err = 1'b0;
    logic [31:0] t_wword = '0;
    logic [31:0] t_addr = '0;
    logic [31:0] hold_data = '0;
    logic        hold_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: size, lane and extension by arithmetic.
    task automatic model_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] data, output logic err, output int lat,
                             output int wcyc, output logic [31:0] wword);
        int unsigned idx, nbytes, off, f;
        logic [31:0] w, mask, v;
        bit st, legal, mis;
        idx = a[5:2];
        w   = model_mem[idx];
        st  = op[3];
        f   = op[2:0];
        legal  = st ? (f <= 2) : (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
        nbytes = !legal ? 4 : ((f % 4) == 0 ? 1 : ((f % 4) == 1 ? 2 : 4));
        mis    = (a[1:0] % nbytes) != 0;
        data = '0; err = 1'b0; wword = '0; wcyc = 0; lat = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (!legal || mis) begin
            err = 1'b1;
            lat = 1;
            return;
        end
`endif
        off  = (a[1:0] / nbytes) * nbytes;
        mask = (nbytes == 1) ? 32'hFF : ((nbytes == 2) ? 32'hFFFF : 32'hFFFF_FFFF);
        if (st) begin
            if (nbytes == 4) begin
                wword = wd; lat = 2; wcyc = 1;
            end else begin
                wword = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
                lat = 4; wcyc = 3;
            end
            model_mem[idx] = wword;
        end else begin
            v = (w >> (8 * off)) & mask;
            if (nbytes < 4 && f < 4 && v >= ((mask + 1) / 2)) v = v | ~mask;
            data = v;
            lat  = 3;
        end
    endtask

    // Single compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        int k;
        bit busy;
        k    = cyc - acc_edge + 1;
        busy = active && k >= 1 && k <= t_lat;
        if (busy && k == t_lat) begin
            hold_data = t_data;
            hold_err  = t_err;
        end
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, busy && k == t_lat});
        check("req_ready", {31'b0, req_ready}, {31'b0, !busy});
        check("mem_rw",    {31'b0, mem_rw},    {31'b0, !(busy && t_wcyc != 0 && k == t_wcyc)});
        check("rsp_data",  rsp_data, hold_data);
        check("rsp_err",   {31'b0, rsp_err}, {31'b0, hold_err});
        if (busy && !t_err && k == 1)
            check("mem_addr", mem_addr, t_addr);
        if (busy && t_wcyc != 0 && k == t_wcyc)
            check("mem_wdata", mem_wdata, t_wword);
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
        acc_edge  = cyc + 1;
        t_addr    = {a[31:2], 2'b00};
        active    = 1;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 4'hF;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
    endtask

    // Apply one request; the model result is pinned against a hand value.
    task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] lit_data, input logic lit_err);
        logic [31:0] d, ww;
        logic e;
        int l, w;
        model_txn(op, a, wd, d, e, l, w, ww);
        check($sformatf("%s_model_data", name), d, lit_data);
        check($sformatf("%s_model_err", name), {31'b0, e}, {31'b0, lit_err});
        t_lat = l; t_wcyc = w; t_data = d; t_err = e; t_wword = ww;
        issue(op, a, wd);
        repeat (l + 1) @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] d;
        logic        e;
    } vec_t;
    vec_t tbl[$];

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 16; i++) begin ram[i] = '0; model_mem[i] = '0; end
        ram[0] = 32'h0000_BEEF; model_mem[0] = 32'h0000_BEEF;
        #1;
        check("rst_mem_rw",    {31'b0, mem_rw},    32'd1);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_mem_addr",  mem_addr,  32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rsp_data",  rsp_data,  32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // SB aborted by reset in its WR cycle.
        t_lat = 4; t_wcyc = 3; t_data = '0; t_err = 1'b0; t_wword = 32'h0000_BE11;
        issue(4'b1000, 32'h0, 32'h11);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0; active = 0; hold_data = '0; hold_err = 1'b0;
        #1;
        check("abort_mem_rw",    {31'b0, mem_rw},    32'd1);
        check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("abort_req_ready", {31'b0, req_ready}, 32'd1);
        check("abort_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        tbl.push_back('{"lw0",   4'b0010, 32'h0, 32'h0,        32'h0000_BEEF, 1'b0});
        tbl.push_back('{"lb0",   4'b0000, 32'h0, 32'h0,        32'hFFFF_FFEF, 1'b0});
        tbl.push_back('{"lbu1",  4'b0100, 32'h1, 32'h0,        32'h0000_00BE, 1'b0});
        tbl.push_back('{"lh0",   4'b0001, 32'h0, 32'h0,        32'hFFFF_BEEF, 1'b0});
        tbl.push_back('{"lhu2",  4'b0101, 32'h2, 32'h0,        32'h0000_0000, 1'b0});
        tbl.push_back('{"sb3",   4'b1000, 32'h3, 32'hAB12,     32'h0,         1'b0});
        tbl.push_back('{"lw0b",  4'b0010, 32'h0, 32'h0,        32'h1200_BEEF, 1'b0});
        tbl.push_back('{"sh2",   4'b1001, 32'h2, 32'h5555_CAFE, 32'h0,        1'b0});
        tbl.push_back('{"lw0c",  4'b0010, 32'h0, 32'h0,        32'hCAFE_BEEF, 1'b0});
        tbl.push_back('{"lb3",   4'b0000, 32'h3, 32'h0,        32'hFFFF_FFCA, 1'b0});
        tbl.push_back('{"lhu2b", 4'b0101, 32'h2, 32'h0,        32'h0000_CAFE, 1'b0});
`ifdef LSU_MISALIGN_TRAP_EN
        tbl.push_back('{"lw2",   4'b0010, 32'h2, 32'h0,        32'h0,         1'b1});
`else
        tbl.push_back('{"lw2",   4'b0010, 32'h2, 32'h0,        32'hCAFE_BEEF, 1'b0});
`endif
        tbl.push_back('{"sw4",   4'b1010, 32'h4, 32'hDEAD_BEEF, 32'h0,        1'b0});
        tbl.push_back('{"lw4",   4'b0010, 32'h4, 32'h0,        32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{"lb7",   4'b0000, 32'h7, 32'h0,        32'hFFFF_FFDE, 1'b0});
`ifdef LSU_MISALIGN_TRAP_EN
        tbl.push_back('{"sh5",   4'b1001, 32'h5, 32'h1234,     32'h0,         1'b1});
        tbl.push_back('{"lw4b",  4'b0010, 32'h4, 32'h0,        32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{"sundef",4'b1011, 32'h8, 32'h77,       32'h0,         1'b1});
        tbl.push_back('{"lw8",   4'b0010, 32'h8, 32'h0,        32'h0,         1'b0});
`else
        tbl.push_back('{"sh5",   4'b1001, 32'h5, 32'h1234,     32'h0,         1'b0});
        tbl.push_back('{"lw4b",  4'b0010, 32'h4, 32'h0,        32'hDEAD_1234, 1'b0});
        tbl.push_back('{"sundef",4'b1011, 32'h8, 32'h77,       32'h0,         1'b0});
        tbl.push_back('{"lw8",   4'b0010, 32'h8, 32'h0,        32'h0000_0077, 1'b0});
`endif
        tbl.push_back('{"lbu11", 4'b0100, 32'hB, 32'h0,        32'h0,         1'b0});

        // First read after the aborted SB must see the untouched word.
        run("lw_after_abort", 4'b0010, 32'h0, 32'h0, 32'h0000_BEEF, 1'b0);
        foreach (tbl[i]) run(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].d, tbl[i].e);

        check("ram_word1", ram[1], model_mem[1]);
        check("ram_word2", ram[2], model_mem[2]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
